bist_fail_logger: RTL and testbench
===================================

// Module: bist_fail_logger
// PURPOSE
//  Downstream companion to the memory BIST controller. Snoops the BIST-to-memory read
//  traffic and aligns expected data with read data across the memory read latency.
//  Compares them and logs each failing (address, syndrome) pair into a small FIFO.
//  The host or scan side drains the FIFO for redundancy analysis after or during the test.
// PARAMETERS
//  MEM_ADDR_WIDTH  10  memory address width, matches BIST controller
//  MEM_DATA_WIDTH  32  memory data width, matches BIST controller
//  READ_LATENCY     1  cycles from read request (enable & !write) to valid mem_rdata; legal 1..4
//  LOG_DEPTH        8  failure FIFO entries; power of two, >=2
// PORTS
//  clk              in   1                clock, all logic rising-edge
//  rst_n            in   1                asynchronous active-low reset
//  log_clear        in   1                sync clear of FIFO, counters, flags, pipeline
//  mem_addr         in   MEM_ADDR_WIDTH   snooped BIST address
//  mem_enable       in   1                snooped BIST enable
//  mem_write        in   1                snooped BIST write strobe
//  exp_data         in   MEM_DATA_WIDTH   expected read data, valid with the read request
//  mem_rdata        in   MEM_DATA_WIDTH   memory read data, READ_LATENCY after request
//  log_valid        out  1                FIFO head valid (first-word-fall-through)
//  log_ready        in   1                pop head when log_valid & log_ready
//  log_addr         out  MEM_ADDR_WIDTH   head entry failing address
//  log_syndrome     out  MEM_DATA_WIDTH   head entry mem_rdata ^ exp_data
//  log_count        out  $clog2(LOG_DEPTH)+1  entries currently stored
//  fail_total       out  32               total mismatches seen, saturates at 32'hFFFF_FFFF
//  first_fail_addr  out  MEM_ADDR_WIDTH   address of first mismatch since reset/clear
//  any_fail         out  1                sticky: any mismatch since reset/clear
//  overflow         out  1                sticky: a mismatch was dropped because FIFO full
//  fail_bitmap      out  MEM_DATA_WIDTH   OR of all syndromes (see CONFIGURATION)
// BEHAVIOUR
//  - Reset: every output and internal register is 0; FIFO empty; pipeline valid bits 0.
//  - Capture: rd_req = mem_enable & ~mem_write. {rd_req, mem_addr, exp_data} enter a
//    READ_LATENCY-deep shift pipe. At the pipe end, if the valid bit is set, compare
//    against mem_rdata sampled that same cycle.
//  - Mismatch when (mem_rdata ^ exp_pipe) != 0. Writes and idle cycles never compare.
//  - On mismatch, all updates take effect the next edge:
//    fail_total += 1 unless saturated.
//    first_fail_addr loads only if any_fail was 0.
//    any_fail <= 1.
//    Push {addr, syndrome} into the FIFO.
//  - Push acceptance: push accepted if FIFO not full, or if a pop occurs the same cycle.
//    Full with no pop: entry dropped, overflow <= 1, fail_total still increments.
//  - Pop: log_valid & log_ready removes the head; the next entry appears the following cycle.
//    log_ready while empty has no effect.
//  - Simultaneous push + pop: log_count unchanged; ordering preserved (strict FIFO).
//  - Pointers wrap modulo LOG_DEPTH. log_count ranges 0..LOG_DEPTH.
//  - Empty: log_valid = 0, log_addr = 0, log_syndrome = 0 (head outputs masked).
//  - log_clear (synchronous, highest priority): the next edge empties the FIFO,
//    zeroes fail_total, first_fail_addr, any_fail, overflow and fail_bitmap, and
//    invalidates in-flight pipe entries. A compare or pop in the clear cycle is discarded.
//  - Reset mid-test: async clear of all state; in-flight reads are lost.
//  - No FSM beyond the FIFO pointers. Latency from read request to log_valid is
//    READ_LATENCY+1 cycles when the FIFO is empty.
// CONFIGURATION
//  BIST_FAIL_LOG_BITMAP_EN defined: fail_bitmap <= fail_bitmap | syndrome on every
//    mismatch, including dropped ones. Cleared by reset/log_clear. Used for column repair.
//  Not defined: fail_bitmap tied to 0 and no bitmap register is built.
// STRUCTURE
//  Shared package/header bist_pkg (bist_pkg.vh):
//    localparam BIST_FAIL_CNT_W = 32
//    log-entry width macro: MEM_ADDR_WIDTH + MEM_DATA_WIDTH
//    READ_LATENCY legal-range checks
//  Sub-module bist_fail_fifo: synchronous FWFT FIFO with WIDTH and DEPTH parameters and
//    push/pop/full/empty/count. The top holds the latency pipe, compare logic, counters,
//    sticky flags and bitmap.
// TESTING
//  1. Reset, then 16 reads, READ_LATENCY=1, rdata==exp -> log_valid=0, fail_total=0,
//     any_fail=0.
//  2. Read addr 0x005, exp 0xA5A5A5A5, rdata 0xA5A5A5A4 -> 2 cycles later: log_valid=1,
//     log_addr=0x005, log_syndrome=0x00000001, first_fail_addr=0x005.
//  3. LOG_DEPTH=8, 10 failing reads, log_ready=0 -> log_count=8, overflow=1,
//     fail_total=10; drain returns the first 8 addresses in order.
//  4. FIFO full, failing read arrives the same cycle as a pop -> accepted, log_count
//     stays 8, overflow stays 0.
//  5. READ_LATENCY=3, interleaved writes and reads, fail on third read -> only the read
//     is logged, with the correct address; writes never compared.
//  6. Fails at 0x010 and 0x020, then log_clear pulsed with a fail in flight -> all
//     outputs 0 the next cycle; in-flight fail not logged. With BIST_FAIL_LOG_BITMAP_EN,
//     fail_bitmap is 0x00000011 before the clear for syndromes 0x1 and 0x10.

Source files
------------

// File: rtl/bist_fail_logger_pkg.sv
// Shared constants and elaboration helpers for the BIST failure logger.
package bist_fail_logger_pkg;

    localparam int unsigned BIST_FAIL_CNT_W = 32;
    localparam int unsigned READ_LATENCY_MIN = 1;
    localparam int unsigned READ_LATENCY_MAX = 4;

    function automatic int unsigned log_entry_w(int unsigned addr_w, int unsigned data_w);
        return addr_w + data_w;
    endfunction

    function automatic bit read_latency_legal(int unsigned lat);
        return (lat >= READ_LATENCY_MIN) && (lat <= READ_LATENCY_MAX);
    endfunction

    function automatic bit log_depth_legal(int unsigned depth);
        return (depth >= 2) && ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/bist_fail_logger_if.sv
// Snoop, log-drain and status signals of the BIST failure logger.
interface bist_fail_logger_if #(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned LOG_DEPTH      = 8
);
    localparam int unsigned CntW = $clog2(LOG_DEPTH) + 1;

    logic                      log_clear;
    logic [MEM_ADDR_WIDTH-1:0] mem_addr;
    logic                      mem_enable;
    logic                      mem_write;
    logic [MEM_DATA_WIDTH-1:0] exp_data;
    logic [MEM_DATA_WIDTH-1:0] mem_rdata;
    logic                      log_valid;
    logic                      log_ready;
    logic [MEM_ADDR_WIDTH-1:0] log_addr;
    logic [MEM_DATA_WIDTH-1:0] log_syndrome;
    logic [CntW-1:0]           log_count;
    logic [31:0]               fail_total;
    logic [MEM_ADDR_WIDTH-1:0] first_fail_addr;
    logic                      any_fail;
    logic                      overflow;
    logic [MEM_DATA_WIDTH-1:0] fail_bitmap;

    modport master (
        output log_clear, mem_addr, mem_enable, mem_write, exp_data, mem_rdata, log_ready,
        input  log_valid, log_addr, log_syndrome, log_count, fail_total, first_fail_addr,
               any_fail, overflow, fail_bitmap
    );

    modport slave (
        input  log_clear, mem_addr, mem_enable, mem_write, exp_data, mem_rdata, log_ready,
        output log_valid, log_addr, log_syndrome, log_count, fail_total, first_fail_addr,
               any_fail, overflow, fail_bitmap
    );

endinterface

// File: rtl/bist_fail_logger_fifo.sv
// First-word-fall-through FIFO with sync clear; head data reads as zero while empty.
module bist_fail_logger_fifo #(
    parameter int unsigned WIDTH = 42,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             push_ok, pop_ok;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(DEPTH));
    assign pop_ok  = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot the push needs.
    assign push_ok = push_i & (~full_o | pop_ok);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_ok) wptr_d = wptr_q + 1'b1;
            if (pop_ok)  rptr_d = rptr_q + 1'b1;
            count_d = count_q + CntW'(push_ok) - CntW'(pop_ok);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (push_ok && !clear_i) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/bist_fail_logger.sv
// Aligns expected data with memory read data, logs mismatches into a FIFO and keeps stats.
// Optional column bitmap: define BIST_FAIL_LOG_BITMAP_EN.
module bist_fail_logger
    import bist_fail_logger_pkg::*;
#(
    parameter int unsigned MEM_ADDR_WIDTH = 10,
    parameter int unsigned MEM_DATA_WIDTH = 32,
    parameter int unsigned READ_LATENCY   = 1,
    parameter int unsigned LOG_DEPTH      = 8
) (
    input logic              clk,
    input logic              rst_n,
    bist_fail_logger_if.slave bus
);
    localparam int unsigned EntryW = log_entry_w(MEM_ADDR_WIDTH, MEM_DATA_WIDTH);
    localparam int unsigned CntW   = $clog2(LOG_DEPTH) + 1;
    localparam int unsigned Rl     = READ_LATENCY;

    if (!read_latency_legal(READ_LATENCY)) begin : g_bad_latency
        $error("bist_fail_logger: READ_LATENCY out of range 1..4");
    end
    if (!log_depth_legal(LOG_DEPTH)) begin : g_bad_depth
        $error("bist_fail_logger: LOG_DEPTH must be a power of two >= 2");
    end

    // Latency pipe: stage 0 captures the request, stage Rl-1 lines up with mem_rdata.
    logic [Rl-1:0]             pipe_vld_q, pipe_vld_d;
    logic [MEM_ADDR_WIDTH-1:0] pipe_addr_q [Rl];
    logic [MEM_DATA_WIDTH-1:0] pipe_exp_q  [Rl];

    logic                      rd_req;
    logic [MEM_DATA_WIDTH-1:0] syndrome;
    logic [MEM_ADDR_WIDTH-1:0] cmp_addr;
    logic                      mismatch;
    logic                      pop;
    logic                      drop;

    logic                      fifo_full, fifo_empty;
    logic [EntryW-1:0]         fifo_rdata;
    logic [CntW-1:0]           fifo_count;

    logic [BIST_FAIL_CNT_W-1:0] fail_total_q, fail_total_d;
    logic [MEM_ADDR_WIDTH-1:0]  first_addr_q, first_addr_d;
    logic                       any_fail_q, any_fail_d;
    logic                       overflow_q, overflow_d;

    assign rd_req = bus.mem_enable & ~bus.mem_write;

    always_comb begin
        pipe_vld_d = '0;
        if (!bus.log_clear) begin
            pipe_vld_d[0] = rd_req;
            for (int i = 1; i < int'(Rl); i++) pipe_vld_d[i] = pipe_vld_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_vld_q <= '0;
            for (int i = 0; i < int'(Rl); i++) begin
                pipe_addr_q[i] <= '0;
                pipe_exp_q[i]  <= '0;
            end
        end else begin
            pipe_vld_q     <= pipe_vld_d;
            pipe_addr_q[0] <= bus.mem_addr;
            pipe_exp_q[0]  <= bus.exp_data;
            for (int i = 1; i < int'(Rl); i++) begin
                pipe_addr_q[i] <= pipe_addr_q[i-1];
                pipe_exp_q[i]  <= pipe_exp_q[i-1];
            end
        end
    end

    assign cmp_addr = pipe_addr_q[Rl-1];
    assign syndrome = bus.mem_rdata ^ pipe_exp_q[Rl-1];
    assign mismatch = pipe_vld_q[Rl-1] & (|syndrome) & ~bus.log_clear;
    assign pop      = ~fifo_empty & bus.log_ready & ~bus.log_clear;
    assign drop     = mismatch & fifo_full & ~pop;

    bist_fail_logger_fifo #(
        .WIDTH (EntryW),
        .DEPTH (LOG_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (bus.log_clear),
        .push_i  (mismatch),
        .pop_i   (pop),
        .wdata_i ({cmp_addr, syndrome}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        fail_total_d = fail_total_q;
        first_addr_d = first_addr_q;
        any_fail_d   = any_fail_q;
        overflow_d   = overflow_q;
        if (bus.log_clear) begin
            fail_total_d = '0;
            first_addr_d = '0;
            any_fail_d   = 1'b0;
            overflow_d   = 1'b0;
        end else if (mismatch) begin
            if (!(&fail_total_q)) fail_total_d = fail_total_q + 1'b1;
            if (!any_fail_q) first_addr_d = cmp_addr;
            any_fail_d = 1'b1;
            if (drop) overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_total_q <= '0;
            first_addr_q <= '0;
            any_fail_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            fail_total_q <= fail_total_d;
            first_addr_q <= first_addr_d;
            any_fail_q   <= any_fail_d;
            overflow_q   <= overflow_d;
        end
    end

`ifdef BIST_FAIL_LOG_BITMAP_EN
    // Dropped mismatches still mark their failing columns.
    logic [MEM_DATA_WIDTH-1:0] bitmap_q, bitmap_d;

    always_comb begin
        bitmap_d = bitmap_q;
        if (bus.log_clear) bitmap_d = '0;
        else if (mismatch) bitmap_d = bitmap_q | syndrome;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bitmap_q <= '0;
        else        bitmap_q <= bitmap_d;
    end

    assign bus.fail_bitmap = bitmap_q;
`else
    assign bus.fail_bitmap = '0;
`endif

    assign bus.log_valid       = ~fifo_empty;
    assign bus.log_addr        = fifo_rdata[EntryW-1:MEM_DATA_WIDTH];
    assign bus.log_syndrome    = fifo_rdata[MEM_DATA_WIDTH-1:0];
    assign bus.log_count       = fifo_count;
    assign bus.fail_total      = fail_total_q;
    assign bus.first_fail_addr = first_addr_q;
    assign bus.any_fail        = any_fail_q;
    assign bus.overflow        = overflow_q;

endmodule

// File: tb/tb_bist_fail_logger.sv
// Randomized bench: two loggers (read latency 1 and 3) against a queue-based reference model.
module tb_bist_fail_logger;
    localparam int unsigned AW    = 10;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned RL0   = 1;
    localparam int unsigned RL1   = 3;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bist_fail_logger_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .LOG_DEPTH(DEPTH)) if0 ();
    bist_fail_logger_if #(.MEM_ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .LOG_DEPTH(DEPTH)) if1 ();

    bist_fail_logger #(
        .MEM_ADDR_WIDTH (AW), .MEM_DATA_WIDTH (DW), .READ_LATENCY (RL0), .LOG_DEPTH (DEPTH)
    ) u_dut0 (.clk (clk), .rst_n (rst_n), .bus (if0));

    bist_fail_logger #(
        .MEM_ADDR_WIDTH (AW), .MEM_DATA_WIDTH (DW), .READ_LATENCY (RL1), .LOG_DEPTH (DEPTH)
    ) u_dut1 (.clk (clk), .rst_n (rst_n), .bus (if1));

    logic          ob_valid [2];
    logic [AW-1:0] ob_addr  [2];
    logic [DW-1:0] ob_synd  [2];
    logic [CW-1:0] ob_count [2];
    logic [31:0]   ob_total [2];
    logic [AW-1:0] ob_first [2];
    logic          ob_any   [2];
    logic          ob_ovf   [2];
    logic [DW-1:0] ob_bmp   [2];

    assign ob_valid[0] = if0.log_valid;       assign ob_valid[1] = if1.log_valid;
    assign ob_addr[0]  = if0.log_addr;        assign ob_addr[1]  = if1.log_addr;
    assign ob_synd[0]  = if0.log_syndrome;    assign ob_synd[1]  = if1.log_syndrome;
    assign ob_count[0] = if0.log_count;       assign ob_count[1] = if1.log_count;
    assign ob_total[0] = if0.fail_total;      assign ob_total[1] = if1.fail_total;
    assign ob_first[0] = if0.first_fail_addr; assign ob_first[1] = if1.first_fail_addr;
    assign ob_any[0]   = if0.any_fail;        assign ob_any[1]   = if1.any_fail;
    assign ob_ovf[0]   = if0.overflow;        assign ob_ovf[1]   = if1.overflow;
    assign ob_bmp[0]   = if0.fail_bitmap;     assign ob_bmp[1]   = if1.fail_bitmap;

    // Reference model: logged entries as queues, reads in flight keyed by compare cycle.
    logic [AW+DW-1:0] m_log0 [$];
    logic [AW+DW-1:0] m_log1 [$];
    logic [31:0]      m_total [2];
    logic [AW-1:0]    m_first [2];
    bit               m_any   [2];
    bit               m_ovf   [2];
    logic [DW-1:0]    m_bmp   [2];
    bit               p_v  [2][8];
    logic [AW-1:0]    p_a  [2][8];
    logic [DW-1:0]    p_s  [2][8];
    logic [DW-1:0]    p_rd [2][8];

    int total_checks = 0;
    int bad_checks   = 0;
    int cyc          = 0;

    task automatic check_eq(string tag, logic [63:0] got, logic [63:0] exp);
        total_checks++;
        if (got !== exp) begin
            bad_checks++;
            $display("FAIL %s at cycle %0d: got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    function automatic int unsigned rl_of(int d);
        return (d == 0) ? RL0 : RL1;
    endfunction

    function automatic int log_size(int d);
        return (d == 0) ? m_log0.size() : m_log1.size();
    endfunction

    function automatic logic [AW+DW-1:0] log_head(int d);
        if (log_size(d) == 0) return '0;
        return (d == 0) ? m_log0[0] : m_log1[0];
    endfunction

    task automatic model_clear(int d);
        if (d == 0) m_log0.delete(); else m_log1.delete();
        m_total[d] = 0;
        m_first[d] = '0;
        m_any[d]   = 0;
        m_ovf[d]   = 0;
        m_bmp[d]   = '0;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            model_clear(d);
            for (int j = 0; j < 8; j++) begin
                p_v[d][j]  = 0;
                p_rd[d][j] = $urandom;
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            logic [AW+DW-1:0] h;
            logic [DW-1:0]    eb;
            h = log_head(d);
`ifdef BIST_FAIL_LOG_BITMAP_EN
            eb = m_bmp[d];
`else
            eb = '0;
`endif
            check_eq($sformatf("d%0d log_valid", d), 64'(ob_valid[d]), 64'(log_size(d) > 0));
            check_eq($sformatf("d%0d log_count", d), 64'(ob_count[d]), 64'(log_size(d)));
            check_eq($sformatf("d%0d log_addr", d), 64'(ob_addr[d]), 64'(h[AW+DW-1:DW]));
            check_eq($sformatf("d%0d log_syndrome", d), 64'(ob_synd[d]), 64'(h[DW-1:0]));
            check_eq($sformatf("d%0d fail_total", d), 64'(ob_total[d]), 64'(m_total[d]));
            check_eq($sformatf("d%0d first_fail_addr", d), 64'(ob_first[d]), 64'(m_first[d]));
            check_eq($sformatf("d%0d any_fail", d), 64'(ob_any[d]), 64'(m_any[d]));
            check_eq($sformatf("d%0d overflow", d), 64'(ob_ovf[d]), 64'(m_ovf[d]));
            check_eq($sformatf("d%0d fail_bitmap", d), 64'(ob_bmp[d]), 64'(eb));
        end
    endtask

    task automatic drive_idle();
        if0.log_clear = 0; if0.mem_enable = 0; if0.mem_write = 0; if0.log_ready = 0;
        if1.log_clear = 0; if1.mem_enable = 0; if1.mem_write = 0; if1.log_ready = 0;
        if0.mem_addr = '0; if0.exp_data = '0; if0.mem_rdata = '0;
        if1.mem_addr = '0; if1.exp_data = '0; if1.mem_rdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One clock: drive a snoop cycle, advance the model, then compare after the edge.
    task automatic step(bit en, bit wr, logic [AW-1:0] a, logic [DW-1:0] e,
                        logic [DW-1:0] synd, bit rdy, bit clr);
        int s;
        s = cyc % 8;
        if0.mem_enable = en; if0.mem_write = wr; if0.mem_addr = a; if0.exp_data = e;
        if1.mem_enable = en; if1.mem_write = wr; if1.mem_addr = a; if1.exp_data = e;
        if0.log_ready = rdy; if0.log_clear = clr; if0.mem_rdata = p_rd[0][s];
        if1.log_ready = rdy; if1.log_clear = clr; if1.mem_rdata = p_rd[1][s];
        for (int d = 0; d < 2; d++) begin
            int               ns;
            bit               mm;
            logic [AW+DW-1:0] ent;
            ns = (cyc + int'(rl_of(d))) % 8;
            p_v[d][ns]  = en && !wr;
            p_a[d][ns]  = a;
            p_s[d][ns]  = synd;
            p_rd[d][ns] = e ^ synd;
            if (clr) for (int j = 1; j <= int'(rl_of(d)); j++) p_v[d][(cyc + j) % 8] = 0;
            mm  = p_v[d][s] && (p_s[d][s] != 0) && !clr;
            ent = {p_a[d][s], p_s[d][s]};
            p_v[d][s]  = 0;
            p_rd[d][s] = $urandom;
            if (clr) begin
                model_clear(d);
            end else begin
                if (rdy && log_size(d) > 0) begin
                    if (d == 0) void'(m_log0.pop_front()); else void'(m_log1.pop_front());
                end
                if (mm) begin
                    if (m_total[d] != 32'hFFFF_FFFF) m_total[d] = m_total[d] + 1;
                    if (!m_any[d]) m_first[d] = ent[AW+DW-1:DW];
                    m_any[d] = 1;
                    m_bmp[d] = m_bmp[d] | ent[DW-1:0];
                    if (log_size(d) < int'(DEPTH)) begin
                        if (d == 0) m_log0.push_back(ent); else m_log1.push_back(ent);
                    end else begin
                        m_ovf[d] = 1;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic idle(int n, bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, '0, rdy, 0);
    endtask

    function automatic logic [DW-1:0] rand_synd();
        logic [DW-1:0] s;
        s = ($urandom_range(1, 0) == 0) ? (DW'(1) << $urandom_range(DW - 1, 0)) : $urandom;
        return (s == '0) ? DW'(1) : s;
    endfunction

    initial begin
        do_reset();

        // Clean reads never log.
        for (int i = 0; i < 16; i++) step(1, 0, AW'(i), $urandom, '0, 0, 0);
        idle(4, 0);

        // Single-bit failure at 0x005.
        step(1, 0, 10'h005, 32'hA5A5_A5A5, 32'h0000_0001, 0, 0);
        idle(4, 0);

        // Fill past capacity with no drain, then drain in order.
        step(0, 0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 10; i++) step(1, 0, AW'(10'h100 + i), $urandom, rand_synd(), 0, 0);
        idle(4, 0);
        idle(10, 1);

        // Full FIFO with a fail arriving alongside a pop.
        step(0, 0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 8; i++) step(1, 0, AW'(10'h200 + i), $urandom, rand_synd(), 0, 0);
        idle(4, 0);
        step(1, 0, 10'h2FF, $urandom, rand_synd(), 0, 0);
        step(0, 0, '0, '0, '0, 1, 0);
        idle(4, 0);
        idle(10, 1);

        // Interleaved writes (corrupt-looking) and reads; only the third read fails.
        step(0, 0, '0, '0, '0, 0, 1);
        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) step(1, 1, AW'(10'h300 + i), $urandom, rand_synd(), 0, 0);
            else step(1, 0, AW'(10'h300 + i), $urandom, (i == 5) ? rand_synd() : '0, 0, 0);
        end
        idle(6, 0);

        // Two fails build the bitmap, then a clear lands on a fail in flight.
        step(0, 0, '0, '0, '0, 0, 1);
        step(1, 0, 10'h010, $urandom, 32'h0000_0001, 0, 0);
        step(1, 0, 10'h020, $urandom, 32'h0000_0010, 0, 0);
        idle(4, 0);
        step(1, 0, 10'h030, $urandom, 32'h0000_0100, 0, 0);
        step(0, 0, '0, '0, '0, 0, 1);
        idle(5, 0);

        // Random traffic with occasional clears and one mid-test reset.
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            step($urandom_range(3, 0) != 0, $urandom_range(3, 0) == 0, AW'($urandom),
                 $urandom, ($urandom_range(2, 0) == 0) ? rand_synd() : '0,
                 $urandom_range(1, 0) == 1, $urandom_range(99, 0) == 0);
        end
        idle(6, 1);

        $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
        $finish;
    end

endmodule
